// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - instruction-memory fetch handshake between sequencer and imem
interface pc_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             imem_req;
  logic             imem_ack;
  logic [WIDTH-1:0] imem_data;

  modport master (output imem_req, input imem_ack, input imem_data);
  modport slave  (input imem_req, output imem_ack, output imem_data);
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - Hack CPU fetch/execute controller driving the PC strobes
module pc_sequencer #(
  parameter int WIDTH   = 16,
  parameter int PC_LAT  = 1,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [WIDTH-1:0] pc_value,
  input  logic [WIDTH-1:0] a_reg,
  pc_sequencer_if.master   imem,
  output logic [WIDTH-1:0] instr,
  output logic             instr_valid,
  input  logic             exec_done,
  input  logic             zr,
  input  logic             ng,
  output logic             pc_reset,
  output logic             pc_load,
  output logic             pc_inc,
  output logic             halted,
  output logic             fault,
  output logic [2:0]       state
);
  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_IDLE   = 3'd1,
    S_SETTLE = 3'd2,
    S_FETCH  = 3'd3,
    S_EXEC   = 3'd4,
    S_HALT   = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] settle_cnt;
  logic [7:0] tmo_cnt;
  logic       settle_done, tmo_last, ack, jump, self_loop;

  assign settle_done = (settle_cnt == 3'(PC_LAT - 1));
  assign tmo_last    = (tmo_cnt == 8'(TIMEOUT - 1));
  assign ack         = (state_q == S_FETCH) && imem.imem_ack;
  assign jump        = instr[15] & ((instr[2] & ng) | (instr[1] & zr) | (instr[0] & ~zr & ~ng));
  assign self_loop   = (a_reg == pc_value);
  assign state       = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_INIT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:   state_d = S_SETTLE;
      S_SETTLE: if (settle_done) state_d = run ? S_FETCH : S_IDLE;
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH: begin
        // an ack on the last allowed cycle takes priority over the timeout
        if (imem.imem_ack)  state_d = S_EXEC;
        else if (tmo_last)  state_d = S_FAULT;
      end
      S_EXEC:   if (exec_done) state_d = (jump && self_loop) ? S_HALT : S_SETTLE;
      S_HALT:   if (!run) state_d = S_IDLE;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr       <= '0;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
      settle_cnt  <= '0;
      tmo_cnt     <= '0;
    end else begin
      instr_valid <= ack;
      if (ack) instr <= imem.imem_data;
      if (state_q == S_FETCH && !imem.imem_ack && tmo_last) fault <= 1'b1;

      if (state_q == S_SETTLE && !settle_done) begin
        if (settle_cnt != 3'h7) settle_cnt <= settle_cnt + 3'd1;
      end else begin
        settle_cnt <= '0;
      end

      if (state_q == S_FETCH && !imem.imem_ack) begin
        if (tmo_cnt != 8'hff) tmo_cnt <= tmo_cnt + 8'd1;
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

  // strobes are decoded from the registered state, so reset silences them at once
  always_comb begin
    imem.imem_req = 1'b0;
    pc_reset      = 1'b0;
    pc_load       = 1'b0;
    pc_inc        = 1'b0;
    halted        = 1'b0;
    case (state_q)
      S_INIT:  pc_reset = 1'b1;
      S_FETCH: imem.imem_req = 1'b1;
      S_EXEC: begin
        pc_load = exec_done & jump & ~self_loop;
        pc_inc  = exec_done & ~jump;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch/execute controller for the Hack CPU program counter.
- Drives the PC's load/inc/reset controls and runs the instruction-memory fetch handshake with a timeout.
- Latches the fetched instruction and evaluates C-instruction jump conditions from the ALU flags.
- Detects the canonical "jump-to-self" end-of-program loop and parks in HALT.

Parameters:
- WIDTH, 16, instruction/address width.
- PC_LAT, 1, settle cycles after a PC update before the next fetch request (1..7); covers the PC's registered update path.
- TIMEOUT, 15, max cycles imem_req may wait for imem_ack before fault (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  level: execute while high.
- pc_value  in  WIDTH  current PC output.
- a_reg  in  WIDTH  A register (jump target).
- imem_req  out  1  fetch request, address is pc_value.
- imem_ack  in  1  fetch data valid on imem_data this cycle.
- imem_data  in  WIDTH  fetched instruction.
- instr  out  WIDTH  latched instruction register.
- instr_valid  out  1  one-cycle pulse, first EXEC cycle.
- exec_done  in  1  datapath finished current instruction; zr/ng valid this cycle.
- zr  in  1  ALU zero flag.
- ng  in  1  ALU negative flag.
- pc_reset  out  1  to PC reset.
- pc_load  out  1  to PC load.
- pc_inc  out  1  to PC inc.
- halted  out  1  high while in HALT.
- fault  out  1  sticky fetch-timeout flag, cleared only by reset.
- state  out  3  encoded state, for debug.

Behaviour:
- States and encodings: INIT=0, IDLE=1, SETTLE=2, FETCH=3, EXEC=4, HALT=5, FAULT=6.
- Reset (async) forces:
  - state=INIT, instr=0, instr_valid=0, fault=0;
  - settle and timeout counters = 0.
- Control outputs:
  - imem_req, pc_load, pc_inc are combinational decodes of state and inputs, so they are 0 during reset.
  - pc_reset is 1 in INIT.
- INIT:
  - Asserts pc_reset for exactly one cycle, then goes to SETTLE.
  - The settle count is loaded so the first fetch sees PC=0.
- SETTLE:
  - Counts PC_LAT cycles.
  - At the end: go to FETCH if run=1, else IDLE.
- IDLE:
  - All control outputs 0.
  - run=1 -> FETCH next cycle.
- FETCH:
  - imem_req=1; timeout counter increments each cycle without ack.
  - imem_ack is sampled only while imem_req=1.
  - On ack: instr<=imem_data, counter cleared, go to EXEC.
  - If counter reaches TIMEOUT with no ack: fault<=1, go to FAULT.
  - Ack on the TIMEOUT-th cycle wins over fault.
  - run is ignored once in FETCH.
- EXEC:
  - instr_valid=1 on the first EXEC cycle only.
  - Waits for exec_done; exec_done may arrive in that same first cycle.
  - On the exec_done cycle, jump = instr[15] & ((instr[2]&ng) | (instr[1]&zr) | (instr[0]&~zr&~ng)).
  - A-instructions (instr[15]=0) never jump.
  - jump & (a_reg==pc_value): no PC strobe; go to HALT.
  - jump otherwise: pc_load=1 for that cycle only; go to SETTLE.
  - no jump: pc_inc=1 for that cycle only; go to SETTLE.
- pc_load and pc_inc are never both high; pc_reset is never high with either.
- HALT:
  - halted=1, no requests.
  - run=0 -> IDLE; resumption re-fetches the same PC.
- FAULT:
  - fault=1, no requests, PC untouched.
  - Exit only by reset.
- Reset mid-operation: immediately abandons FETCH/EXEC; any late imem_ack is ignored.
- Counters saturate and never wrap.
- PC wrap 0xFFFF->0x0000 belongs to the PC, not this block.

Test Plan:
- Reset pulse, run=0 -> pc_reset=1 for one cycle after release; state then sits in IDLE; imem_req=0, instr=0.
- run=1, memory acks 0x0005 two cycles after req -> instr=0x0005; instr_valid pulses once; exec_done gives pc_inc=1 for one cycle and pc_load=0; next imem_req comes PC_LAT cycles later.
- instr=0xE302 (JEQ), a_reg=0x0010, pc_value=0x0003:
  - zr=1 -> pc_load=1;
  - repeat with zr=0, ng=1 -> pc_inc=1.
- instr=0xEA87 (0;JMP), a_reg=pc_value=0x0007 -> halted=1 with no pc_load and no further imem_req; run=0 -> IDLE.
- TIMEOUT=15, no ack -> fault=1 on the 15th FETCH cycle; imem_req drops; fault holds until reset.
- Assert reset during FETCH with a late ack -> imem_req=0 immediately; instr stays 0x0000; INIT sequence replays.
